hazard_fwd_unit: RTL and testbench
==================================

// Module: hazard_fwd_unit
// PURPOSE
//  Producer of EX forwarding selects plus load-use stall and branch-flush control for the 5-stage core.
//  Keeps a shadow pipeline of destination info (ID/EX, EX/MEM, MEM/WB) and compares the ID-stage sources against it.
//  Forward selects are registered when an instruction advances ID->EX, so they are valid for that instruction's whole EX cycle.
// PARAMETERS
//  REG_ADDR_W  5   register address width (x0..x31)
//  CNT_W       32  width of perf counters (HAZ_PERF_CNT_EN only)
// PORTS
//  i_clk            in   1           core clock, rising edge
//  i_rst_n          in   1           asynchronous active-low reset
//  i_id_valid       in   1           valid instruction in ID
//  i_id_rs1_addr    in   REG_ADDR_W  ID rs1 address
//  i_id_rs2_addr    in   REG_ADDR_W  ID rs2 address
//  i_id_rs1_used    in   1           ID instruction reads rs1
//  i_id_rs2_used    in   1           ID instruction reads rs2
//  i_id_rd_addr     in   REG_ADDR_W  ID destination
//  i_id_rd_wren     in   1           ID instruction writes rd
//  i_id_is_load     in   1           ID instruction is a load
//  i_ex_redirect    in   1           taken branch/jump resolved in EX this cycle
//  i_mem_stall      in   1           LSU freeze: entire pipeline holds
//  o_forward_a_sel  out  2           EX rs1 select: 00 RF, 01 WB data, 10 EX/MEM ALU result
//  o_forward_b_sel  out  2           EX rs2 select, same encoding
//  o_stall_if_id    out  1           hold PC and IF/ID this cycle
//  o_flush_id_ex    out  1           load bubble into ID/EX this cycle
//  o_flush_if_id    out  1           squash IF/ID this cycle
//  o_stall_count    out  CNT_W       load-use stall cycles (HAZ_PERF_CNT_EN)
//  o_fwd_count      out  CNT_W       non-00 select loads (HAZ_PERF_CNT_EN)
// BEHAVIOUR
//  Reset: all shadow slots valid=0, both selects 00, counters 0; stall/flush outputs therefore 0.
//  Slot = {valid, rd, wren, is_load}. "Producer" = valid & wren & rd!=0. x0 never forwarded or stalled on.
//  load_use (comb) = i_id_valid & ID/EX producer & ID/EX is_load & (rs1_used&rs1==rd | rs2_used&rs2==rd) & !i_ex_redirect.
//  o_stall_if_id = load_use & !i_mem_stall. o_flush_id_ex = (load_use|i_ex_redirect) & !i_mem_stall.
//  o_flush_if_id = i_ex_redirect & !i_mem_stall. Redirect beats load_use in the same cycle.
//  Each edge with !i_mem_stall: MEM/WB<=EX/MEM; EX/MEM<=ID/EX; ID/EX<=(load_use|redirect|!i_id_valid) ? invalid : ID fields.
//  Select update on same edge, per source independently:
//   - bubble inserted (load_use|redirect|!i_id_valid): sel<=00.
//   - else 10 if src used & ID/EX producer & !is_load & rd==src;
//   - else 01 if src used & EX/MEM producer & rd==src (covers loads after 1-cycle stall);
//   - else 00 (MEM/WB case: register file is write-through).
//   Newest producer wins: ID/EX match takes priority over EX/MEM match.
//  i_mem_stall=1: all shadow slots, selects and counters hold; stall/flush outputs 0; redirect re-evaluated when freeze ends.
//  Latency: load-use costs exactly one bubble; ALU-to-ALU back-to-back costs zero.
//  Async reset mid-operation clears everything immediately; first post-reset instructions see 00.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: o_stall_count +1 per cycle o_stall_if_id=1; o_fwd_count +1 per select load with A or B != 00;
//   both saturate at all-ones, never wrap.
//  Not defined: no counter flops; o_stall_count and o_fwd_count tied to 0.
// STRUCTURE
//  Shared package rv_pipe_pkg: fwd_sel_e {FWD_RF=2'b00, FWD_WB=2'b01, FWD_EXMEM=2'b10}; haz_slot_t struct {valid, rd, wren, is_load}.
//  Sub-module fwd_src_match (one per source, comb): src addr/used + two slots -> fwd_sel_e and load-use hit.
//  Top holds slot registers, select registers, stall/flush logic, optional counters.
// TESTING
//  add x5,x1,x2 ; sub x6,x5,x3 -> at sub in EX: fwd_a=10, fwd_b=00; no stall.
//  lw x7,0(x1) ; add x8,x7,x7 -> 1 cycle stall_if_id=1 & flush_id_ex=1; at add in EX fwd_a=fwd_b=01.
//  add x5.. ; nop ; or x9,x5,x0 -> fwd_a=01; add x0,.. ; sub x6,x0,x0 -> fwd 00, no stall.
//  add x5.. ; add x5.. ; sub x6,x5,x5 -> both selects 10 (newest wins).
//  lw x7 in ID/EX with dependent in ID and i_ex_redirect=1 same cycle -> stall_if_id=0, flush_if_id=1, flush_id_ex=1, sel 00.
//  i_mem_stall=1 for 3 cycles mid load-use -> outputs 0, state held; after release stall resumes; with HAZ_PERF_CNT_EN o_stall_count=1.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared forwarding-select encoding and hazard shadow-slot type for the 5-stage core
package rv_pipe_pkg;
  localparam int SLOT_RD_W = 5;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_EXMEM = 2'b10} fwd_sel_e;
  typedef struct packed {
    logic                 valid;
    logic [SLOT_RD_W-1:0] rd;
    logic                 wren;
    logic                 is_load;
  } haz_slot_t;
  function automatic logic is_producer(input haz_slot_t s);
    return s.valid & s.wren & (s.rd != '0);
  endfunction
endpackage

// File: rtl/fwd_src_match.sv
// fwd_src_match: compares one ID source against the ID/EX and EX/MEM slots; newest producer wins
module fwd_src_match
  import rv_pipe_pkg::*;
(
  input  logic [SLOT_RD_W-1:0] i_src,
  input  logic                 i_used,
  input  haz_slot_t            i_idex,
  input  haz_slot_t            i_exmem,
  output fwd_sel_e             o_sel,
  output logic                 o_load_hit
);
  logic hit_idex;
  logic hit_exmem;
  logic unused_exmem_load;
  assign unused_exmem_load = i_exmem.is_load;
  always_comb begin
    hit_idex   = i_used & is_producer(i_idex) & (i_idex.rd == i_src);
    hit_exmem  = i_used & is_producer(i_exmem) & (i_exmem.rd == i_src);
    o_load_hit = hit_idex & i_idex.is_load;
    o_sel      = (hit_idex & !i_idex.is_load) ? FWD_EXMEM : hit_exmem ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: EX forward selects, load-use stall, redirect flush; HAZ_PERF_CNT_EN adds saturating perf counters
module hazard_fwd_unit
  import rv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = SLOT_RD_W,
  parameter int CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_id_rd_addr,
  input  logic                  i_id_rd_wren,
  input  logic                  i_id_is_load,
  input  logic                  i_ex_redirect,
  input  logic                  i_mem_stall,
  output logic [1:0]            o_forward_a_sel,
  output logic [1:0]            o_forward_b_sel,
  output logic                  o_stall_if_id,
  output logic                  o_flush_id_ex,
  output logic                  o_flush_if_id,
  output logic [CNT_W-1:0]      o_stall_count,
  output logic [CNT_W-1:0]      o_fwd_count
);
  haz_slot_t idex_q, idex_d, exmem_q, exmem_d, memwb_q, memwb_d, id_slot;
  fwd_sel_e  sel_a, sel_b;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic hit_a, hit_b, load_use, bubble, adv;
  logic unused_memwb;
  fwd_src_match u_match_a (
    .i_src(i_id_rs1_addr), .i_used(i_id_rs1_used), .i_idex(idex_q), .i_exmem(exmem_q),
    .o_sel(sel_a), .o_load_hit(hit_a)
  );
  fwd_src_match u_match_b (
    .i_src(i_id_rs2_addr), .i_used(i_id_rs2_used), .i_idex(idex_q), .i_exmem(exmem_q),
    .o_sel(sel_b), .o_load_hit(hit_b)
  );
  // MEM/WB is tracked for completeness; the write-through register file covers that distance
  assign unused_memwb = ^memwb_q;
  always_comb begin
    load_use      = i_id_valid & (hit_a | hit_b) & !i_ex_redirect;
    bubble        = load_use | i_ex_redirect | !i_id_valid;
    adv           = !i_mem_stall;
    id_slot       = '{valid: 1'b1, rd: i_id_rd_addr, wren: i_id_rd_wren, is_load: i_id_is_load};
    idex_d        = adv ? (bubble ? '0 : id_slot) : idex_q;
    exmem_d       = adv ? idex_q : exmem_q;
    memwb_d       = adv ? exmem_q : memwb_q;
    fwd_a_d       = adv ? (bubble ? FWD_RF : sel_a) : fwd_a_q;
    fwd_b_d       = adv ? (bubble ? FWD_RF : sel_b) : fwd_b_q;
    o_stall_if_id = load_use & adv;
    o_flush_id_ex = (load_use | i_ex_redirect) & adv;
    o_flush_if_id = i_ex_redirect & adv;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end
  assign o_forward_a_sel = fwd_a_q;
  assign o_forward_b_sel = fwd_b_q;
`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
  always_comb begin
    stall_cnt_d = (o_stall_if_id & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    fwd_cnt_d   = (adv & ({fwd_a_d, fwd_b_d} != '0) & ~&fwd_cnt_q) ? fwd_cnt_q + CNT_W'(1) : fwd_cnt_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end
  assign o_stall_count = stall_cnt_q;
  assign o_fwd_count   = fwd_cnt_q;
`else
  assign o_stall_count = '0;
  assign o_fwd_count   = '0;
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed instruction sequences with a queue scoreboard of expected hazard outputs
module tb_hazard_fwd_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic id_valid = 1'b0, rs1_used = 1'b0, rs2_used = 1'b0, rd_wren = 1'b0, is_load = 1'b0;
  logic ex_redirect = 1'b0, mem_stall = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic [1:0] fa, fb;
  logic st_o, fidex_o, fifid_o;
  logic [31:0] stall_cnt, fwd_cnt;
  int checks = 0;
  int errors = 0;
  typedef struct {string tag; logic [6:0] v;} pipe_exp_t;
  typedef struct {string tag; logic [63:0] v;} cnt_exp_t;
  pipe_exp_t pq[$];
  cnt_exp_t  cq[$];
`ifdef HAZ_PERF_CNT_EN
  localparam int ES = 2, EF = 5;
`else
  localparam int ES = 0, EF = 0;
`endif

  always #5 clk = ~clk;

  hazard_fwd_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_id_rd_addr(rd), .i_id_rd_wren(rd_wren), .i_id_is_load(is_load),
    .i_ex_redirect(ex_redirect), .i_mem_stall(mem_stall),
    .o_forward_a_sel(fa), .o_forward_b_sel(fb), .o_stall_if_id(st_o),
    .o_flush_id_ex(fidex_o), .o_flush_if_id(fifid_o),
    .o_stall_count(stall_cnt), .o_fwd_count(fwd_cnt)
  );

  task automatic chk_pipe();
    pipe_exp_t e;
    logic [6:0] o;
    e = pq.pop_front();
    o = {fa, fb, st_o, fidex_o, fifid_o};
    checks++;
    assert (o === e.v) else begin
      errors++;
      $error("FAIL %s observed {a,b,stall,flush_idex,flush_ifid}=%b expected=%b", e.tag, o, e.v);
    end
  endtask

  task automatic chk_cnt(input string tag, input int s, input int f);
    cnt_exp_t e;
    logic [63:0] o;
    cq.push_back('{tag, {32'(s), 32'(f)}});
    e = cq.pop_front();
    o = {stall_cnt, fwd_cnt};
    checks++;
    assert (o === e.v) else begin
      errors++;
      $error("FAIL %s observed stall/fwd=%0d/%0d expected=%0d/%0d", e.tag, o[63:32], o[31:0], e.v[63:32], e.v[31:0]);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [4:0] r1, r2,
                      input logic u1, u2, input logic [4:0] d, input logic wr, ld, rdr, ms,
                      input logic [1:0] ea, eb, input logic est, efi, eff);
    id_valid = v; rs1 = r1; rs2 = r2; rs1_used = u1; rs2_used = u2;
    rd = d; rd_wren = wr; is_load = ld; ex_redirect = rdr; mem_stall = ms;
    pq.push_back('{tag, {ea, eb, est, efi, eff}});
    @(negedge clk);
    chk_pipe();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input string tag, input logic [4:0] r1, r2, input logic u1, u2,
                     input logic [4:0] d, input logic wr, ld, input logic [1:0] ea, eb,
                     input logic est, efi);
    step(tag, 1'b1, r1, r2, u1, u2, d, wr, ld, 1'b0, 1'b0, ea, eb, est, efi, 1'b0);
  endtask

  task automatic nop(input string tag, input logic [1:0] ea, eb);
    step(tag, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    pq.push_back('{"reset", 7'b0});
    chk_pipe();
    chk_cnt("reset_cnt", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // add x5,x1,x2 ; sub x6,x5,x3
    ins("alu_add", 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 2'b00, 2'b00, 0, 0);
    ins("alu_sub", 5'd5, 5'd3, 1, 1, 5'd6, 1, 0, 2'b00, 2'b00, 0, 0);
    nop("alu_fwd_ex", 2'b10, 2'b00);
    // lw x7 ; add x8,x7,x7
    ins("lw", 5'd1, 5'd0, 1, 0, 5'd7, 1, 1, 2'b00, 2'b00, 0, 0);
    ins("lu_stall", 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 2'b00, 2'b00, 1, 1);
    ins("lu_resume", 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 2'b00, 2'b00, 0, 0);
    nop("lu_fwd_wb", 2'b01, 2'b01);
    // add x5 ; nop ; or x9,x5,x0 ; add x0 ; sub x6,x0,x0
    ins("wb_add", 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 2'b00, 2'b00, 0, 0);
    nop("wb_gap", 2'b00, 2'b00);
    ins("wb_or", 5'd5, 5'd0, 1, 1, 5'd9, 1, 0, 2'b00, 2'b00, 0, 0);
    ins("x0_add", 5'd1, 5'd2, 1, 1, 5'd0, 1, 0, 2'b01, 2'b00, 0, 0);
    ins("x0_sub", 5'd0, 5'd0, 1, 1, 5'd6, 1, 0, 2'b00, 2'b00, 0, 0);
    // add x5 ; add x5 ; sub x6,x5,x5
    ins("new_add1", 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 2'b00, 2'b00, 0, 0);
    ins("new_add2", 5'd3, 5'd4, 1, 1, 5'd5, 1, 0, 2'b00, 2'b00, 0, 0);
    ins("new_sub", 5'd5, 5'd5, 1, 1, 5'd6, 1, 0, 2'b00, 2'b00, 0, 0);
    nop("newest_wins", 2'b10, 2'b10);
    // load-use coinciding with a redirect
    ins("rd_lw", 5'd1, 5'd0, 1, 0, 5'd7, 1, 1, 2'b00, 2'b00, 0, 0);
    step("rd_redirect", 1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 1, 0, 2'b00, 2'b00, 0, 1, 1);
    nop("rd_bubble", 2'b00, 2'b00);
    // LSU freeze over a load-use
    ins("ms_lw", 5'd1, 5'd0, 1, 0, 5'd7, 1, 1, 2'b00, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++)
      step("ms_hold", 1, 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 0);
    ins("ms_release", 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 2'b00, 2'b00, 1, 1);
    ins("ms_resume", 5'd7, 5'd7, 1, 1, 5'd8, 1, 0, 2'b00, 2'b00, 0, 0);
    nop("ms_fwd_wb", 2'b01, 2'b01);
    chk_cnt("perf", ES, EF);
    // async reset while a forward select is live
    ins("pr_add", 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 2'b00, 2'b00, 0, 0);
    ins("pr_sub", 5'd5, 5'd3, 1, 1, 5'd6, 1, 0, 2'b00, 2'b00, 0, 0);
    id_valid = 1; rs1 = 5'd5; rs2 = 5'd6; rs1_used = 1; rs2_used = 1; rd = 5'd9; rd_wren = 1; is_load = 0;
    rst_n = 1'b0;
    #1;
    pq.push_back('{"async_rst", 7'b0});
    chk_pipe();
    chk_cnt("async_rst_cnt", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nop("post_rst", 2'b00, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
